// File: rtl/regfile_dump_streamer.sv
// -----------------------------------------------------------------------------
// regfile_dump_streamer
//
// Purpose:
//   Walks the architectural register file from index 0 to NUM_REGS-1 through a
//   dedicated combinational read port. Each entry is streamed out on a
//   valid/ready interface. A running additive checksum (mod 2^XLEN) of every
//   accepted word is kept so a host can compare the whole file against a
//   golden image in one step.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   start       one-cycle dump request, honoured only when idle
//   abort       synchronous cancel, returns to idle without a done pulse
//   busy        high whenever a dump is in progress
//   done        one-cycle pulse after the last word is accepted
//   rf_rd_addr  register-file read address (holds outside the read cycle)
//   rf_rd_data  register-file read data, combinational from rf_rd_addr
//   dump_valid  stream word valid
//   dump_ready  sink ready
//   dump_idx    register index of the presented word
//   dump_data   register value of the presented word
//   dump_last   marks the word for index NUM_REGS-1
//   checksum    sum of all accepted words of the current/most recent dump
// -----------------------------------------------------------------------------
module regfile_dump_streamer #(
   parameter int NUM_REGS = 32,
   parameter int XLEN     = 32,
   parameter int IDX_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] rf_rd_addr,
   input  logic [XLEN-1:0]  rf_rd_data,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [IDX_W-1:0] dump_idx,
   output logic [XLEN-1:0]  dump_data,
   output logic             dump_last,
   output logic [XLEN-1:0]  checksum
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      SEND   = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dump_valid_q, dump_valid_d;
   logic             dump_last_q, dump_last_d;
   // rf_rd_addr_q doubles as the walk index: it is loaded with the index of
   // the next entry when entering READ and simply holds everywhere else.
   logic [IDX_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
   logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
   logic [XLEN-1:0]  dump_data_q, dump_data_d;
   logic [XLEN-1:0]  checksum_q, checksum_d;

   always_comb begin
      state_d      = state_q;
      rf_rd_addr_d = rf_rd_addr_q;
      dump_idx_d   = dump_idx_q;
      dump_data_d  = dump_data_q;
      checksum_d   = checksum_q;
      dump_last_d  = 1'b0;

      // Abort takes precedence over everything, including a handshake in the
      // same cycle: that word is dropped and the checksum keeps its partial sum.
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d      = READ;
                  rf_rd_addr_d = '0;
                  checksum_d   = '0;
               end
            end
            READ: begin
               state_d     = SEND;
               dump_data_d = rf_rd_data;
               dump_idx_d  = rf_rd_addr_q;
               dump_last_d = (rf_rd_addr_q == LAST_IDX);
            end
            SEND: begin
               if (dump_ready) begin
                  checksum_d = checksum_q + dump_data_q;
                  if (dump_last_q) begin
                     state_d = FINISH;
                  end else begin
                     rf_rd_addr_d = rf_rd_addr_q + IDX_ONE;
                     state_d      = READ;
                  end
               end else begin
                  // Stalled: word and its last flag stay on the bus.
                  dump_last_d = dump_last_q;
               end
            end
            FINISH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // Status outputs are registered, so they are decoded from the next state.
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == FINISH);
      dump_valid_d = (state_d == SEND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         dump_valid_q <= 1'b0;
         dump_last_q  <= 1'b0;
         rf_rd_addr_q <= '0;
         dump_idx_q   <= '0;
         dump_data_q  <= '0;
         checksum_q   <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         dump_valid_q <= dump_valid_d;
         dump_last_q  <= dump_last_d;
         rf_rd_addr_q <= rf_rd_addr_d;
         dump_idx_q   <= dump_idx_d;
         dump_data_q  <= dump_data_d;
         checksum_q   <= checksum_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign dump_valid = dump_valid_q;
   assign dump_last  = dump_last_q;
   assign rf_rd_addr = rf_rd_addr_q;
   assign dump_idx   = dump_idx_q;
   assign dump_data  = dump_data_q;
   assign checksum   = checksum_q;

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_streamer
//
// Scoreboard bench: each dump request pushes the words the sink should accept
// (taken straight from the bench's register-file array) into a queue, and the
// expected checksum is the plain sum of those words. A separate monitor pops
// and compares on every handshake, and checks that a stalled word stays stable.
// -----------------------------------------------------------------------------
module tb_regfile_dump_streamer;

   localparam int NUM_REGS = 32;
   localparam int XLEN     = 32;
   localparam int IDX_W    = 5;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] rf_rd_addr;
   logic [XLEN-1:0]  rf_rd_data;
   logic             dump_valid;
   logic             dump_ready;
   logic [IDX_W-1:0] dump_idx;
   logic [XLEN-1:0]  dump_data;
   logic             dump_last;
   logic [XLEN-1:0]  checksum;

   logic [XLEN-1:0]  regs [NUM_REGS];

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic [XLEN-1:0]  data;
      logic             last;
   } word_t;

   word_t exp_q [$];

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   // Stimulus configuration for the current dump (-1 disables a rule)
   bit cfg_rnd;
   int cfg_stall;
   int cfg_abort;
   int cfg_restart;
   int cfg_rst;
   int stall_cnt;
   bit stalled;
   bit abort_fired;
   bit restart_fired;
   bit rst_fired;

   regfile_dump_streamer #(
      .NUM_REGS (NUM_REGS),
      .XLEN     (XLEN),
      .IDX_W    (IDX_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_last  (dump_last),
      .checksum   (checksum)
   );

   // Combinational register-file read port
   assign rf_rd_data = regs[rf_rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin
      word_t            w;
      bit               hold_valid;
      logic [IDX_W-1:0] hold_idx;
      logic [XLEN-1:0]  hold_data;
      hold_valid = 1'b0;
      hold_idx   = '0;
      hold_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_valid = 1'b0;
         end else begin
            if (done) begin
               done_cnt++;
               chk("done_with_valid", {31'd0, dump_valid}, 32'd0);
            end
            if (dump_valid) chk("valid_while_idle", {31'd0, busy}, 32'd1);
            if (hold_valid) begin
               chk("stall_idx_stable", {27'd0, dump_idx}, {27'd0, hold_idx});
               chk("stall_data_stable", dump_data, hold_data);
            end
            if (dump_valid && dump_ready && !abort) begin
               $display("word idx=%0d data=0x%08h last=%0b cyc=%0d", dump_idx, dump_data, dump_last, cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got idx %0d, required no word", dump_idx);
               end else begin
                  w = exp_q.pop_front();
                  chk("word_idx", {27'd0, dump_idx}, {27'd0, w.idx});
                  chk("word_data", dump_data, w.data);
                  chk("word_last", {31'd0, dump_last}, {31'd0, w.last});
               end
            end
            hold_valid = dump_valid && !dump_ready && !abort;
            hold_idx   = dump_idx;
            hold_data  = dump_data;
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (stall_cnt > 0) begin
         dump_ready = 1'b0;
         stall_cnt--;
      end else if (dump_valid && int'(dump_idx) == cfg_stall && !stalled) begin
         dump_ready = 1'b0;
         stall_cnt  = 2;
         stalled    = 1'b1;
      end else if (cfg_rnd) begin
         dump_ready = ($urandom_range(0, 3) != 0);
      end else begin
         dump_ready = 1'b1;
      end
      if (dump_valid && int'(dump_idx) == cfg_abort && !abort_fired) begin
         abort       = 1'b1;
         dump_ready  = 1'b1;
         abort_fired = 1'b1;
      end
      if (dump_valid && int'(dump_idx) == cfg_restart && !restart_fired) begin
         start         = 1'b1;
         restart_fired = 1'b1;
      end
      if (busy && !dump_valid && !done && int'(rf_rd_addr) == cfg_rst && !rst_fired) begin
         rst       = 1'b1;
         rst_fired = 1'b1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " done"}, {31'd0, done}, 32'd0);
      chk({tag, " dump_valid"}, {31'd0, dump_valid}, 32'd0);
      chk({tag, " dump_last"}, {31'd0, dump_last}, 32'd0);
      chk({tag, " dump_idx"}, {27'd0, dump_idx}, 32'd0);
      chk({tag, " dump_data"}, dump_data, 32'd0);
      chk({tag, " rf_rd_addr"}, {27'd0, rf_rd_addr}, 32'd0);
      chk({tag, " checksum"}, checksum, 32'd0);
   endtask

   task automatic run_dump(input string tag, input bit rnd, input int stall_i, input int abort_i,
                           input int restart_i, input int rst_i, input bit lat);
      int          n_acc;
      logic [31:0] exp_sum;
      int          start_cyc;
      int          base;
      bit          ended;

      cfg_rnd       = rnd;
      cfg_stall     = stall_i;
      cfg_abort     = abort_i;
      cfg_restart   = restart_i;
      cfg_rst       = rst_i;
      stall_cnt     = 0;
      stalled       = 1'b0;
      abort_fired   = 1'b0;
      restart_fired = 1'b0;
      rst_fired     = 1'b0;

      // Words the sink is expected to accept, and their plain sum
      n_acc = NUM_REGS;
      if (abort_i >= 0) n_acc = abort_i;
      else if (rst_i >= 0) n_acc = rst_i;
      exp_q.delete();
      exp_sum = 32'd0;
      for (int i = 0; i < n_acc; i++) begin
         exp_q.push_back('{idx: 5'(i), data: regs[i], last: (i == NUM_REGS - 1)});
         exp_sum = exp_sum + regs[i];
      end

      base = done_cnt;
      @(posedge clk);
      #1;
      start      = 1'b1;
      abort      = 1'b0;
      rst        = 1'b0;
      dump_ready = 1'b1;
      start_cyc  = cyc;
      $display("%s: start at cyc=%0d, %0d words expected", tag, start_cyc, n_acc);
      tick();
      chk({tag, " checksum_cleared"}, checksum, 32'd0);
      chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);

      ended = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         if (done || abort_fired || rst_fired) begin
            ended = 1'b1;
            break;
         end
         tick();
      end
      if (!ended) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got no done/abort/rst within 1000 cycles, required completion", tag);
         return;
      end

      if (rst_fired) begin
         tick();
         check_reset_outputs({tag, " after_rst"});
      end else if (abort_fired) begin
         tick();
         chk({tag, " busy_after_abort"}, {31'd0, busy}, 32'd0);
         chk({tag, " valid_after_abort"}, {31'd0, dump_valid}, 32'd0);
         repeat (4) tick();
         chk({tag, " no_done_on_abort"}, done_cnt - base, 32'd0);
         chk({tag, " partial_checksum"}, checksum, exp_sum);
      end else begin
         if (lat) chk({tag, " done_latency"}, cyc - start_cyc, 32'd65);
         repeat (6) tick();
         chk({tag, " done_count"}, done_cnt - base, 32'd1);
         chk({tag, " checksum"}, checksum, exp_sum);
         chk({tag, " busy_idle"}, {31'd0, busy}, 32'd0);
      end
      chk({tag, " words_left"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      dump_ready  = 1'b0;
      cfg_rnd     = 1'b0;
      cfg_stall   = -1;
      cfg_abort   = -1;
      cfg_restart = -1;
      cfg_rst     = -1;
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 1: ramp pattern, sink always ready
      for (int i = 0; i < NUM_REGS; i++) regs[i] = i * 32'h11;
      run_dump("s1_ramp", 1'b0, -1, -1, -1, -1, 1'b1);
      chk("s1 golden_checksum", checksum, 32'h000020F0);

      // 2: three-cycle stall on idx 5
      run_dump("s2_stall", 1'b0, 5, -1, -1, -1, 1'b0);
      chk("s2 golden_checksum", checksum, 32'h000020F0);

      // 3: checksum wrap-around
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hFFFF_FFFF;
      regs[0] = 32'd0;
      run_dump("s3_wrap", 1'b0, -1, -1, -1, -1, 1'b1);
      chk("s3 golden_checksum", checksum, 32'hFFFF_FFE1);

      // 4: abort together with the idx 10 handshake, then a clean restart
      for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
      run_dump("s4_abort", 1'b0, -1, 10, -1, -1, 1'b0);
      run_dump("s4_restart", 1'b0, -1, -1, -1, -1, 1'b1);

      // 5: start pulse while presenting idx 3 must be ignored
      for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
      run_dump("s5_restart_ignored", 1'b1, -1, -1, 3, -1, 1'b0);

      // 6: reset during the idx 20 read, then a full dump
      for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
      run_dump("s6_rst", 1'b1, -1, -1, -1, 20, 1'b0);
      run_dump("s6_after_rst", 1'b0, -1, -1, -1, -1, 1'b1);

      // Random contents with random backpressure
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
         run_dump($sformatf("rand%0d", r), 1'b1, -1, -1, -1, -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
